// File: rtl/video_timing_meter_pkg.sv
// Shared types and helpers for the video timing meter: FSM states, field widths
// and a saturating incrementer used by every counter in the block.
package video_pkg;

  typedef enum logic [1:0] {WAIT, FIRST, VERIFY, LOCK} state_t;

  localparam int HW  = 11;
  localparam int VW  = 10;
  localparam int HSW = 8;
  localparam int VSW = 5;

  // Increment v, sticking at the all-ones value of a w-bit field (w <= 16).
  function automatic logic [15:0] sat_inc(input logic [15:0] v, input int unsigned w);
    logic [15:0] lim;
    lim = 16'((32'd1 << w) - 32'd1);
    return (v >= lim) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/video_timing_meter_sync_edge.sv
// Synchronizer chain followed by a ce-qualified rise/fall detector; the level and
// edge flags all describe the same (previous) ce sample, so they stay aligned.
module sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic ce,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic lvl_q, lvl_d;
  logic rise_q, rise_d;
  logic fall_q, fall_d;
  logic s;

  assign s = sync_q[SYNC_STAGES-1];

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], din};
    lvl_d  = lvl_q;
    rise_d = rise_q;
    fall_d = fall_q;
    if (ce) begin
      lvl_d  = s;
      rise_d = s & ~lvl_q;
      fall_d = ~s & lvl_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      lvl_q  <= 1'b0;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      lvl_q  <= lvl_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
    end
  end

  // Edge flags are held between ce ticks, so present them only on a tick.
  assign level = lvl_q;
  assign rise  = rise_q & ce;
  assign fall  = fall_q & ce;

endmodule

// File: rtl/video_timing_meter.sv
// Raster timing meter: counts line/frame geometry on ce_pix ticks and publishes a
// per-frame snapshot on VS rise, with a two-frame lock check and a VS watchdog.
module video_timing_meter
  import video_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT_W   = 20
) (
  input  logic           clk_24m,
  input  logic           reset_n,
  input  logic           ce_pix,
  input  logic           hs_in,
  input  logic           vs_in,
  input  logic           blank_in,
  output logic [HW-1:0]  h_total,
  output logic [HSW-1:0] h_sync_w,
  output logic [HW-1:0]  h_active,
  output logic [VW-1:0]  v_total,
  output logic [VSW-1:0] v_sync_w,
  output logic [VW-1:0]  v_active,
  output logic           locked,
  output logic           changed
);

  logic hs_l, hs_r, hs_f, vs_l, vs_r, vs_f, bl_l, bl_r, bl_f;
  logic unused_edges;

  sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_hs (.clk(clk_24m), .rst_n(reset_n), .ce(ce_pix),
    .din(hs_in), .level(hs_l), .rise(hs_r), .fall(hs_f));
  sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_vs (.clk(clk_24m), .rst_n(reset_n), .ce(ce_pix),
    .din(vs_in), .level(vs_l), .rise(vs_r), .fall(vs_f));
  sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_bl (.clk(clk_24m), .rst_n(reset_n), .ce(ce_pix),
    .din(blank_in), .level(bl_l), .rise(bl_r), .fall(bl_f));

  assign unused_edges = hs_f ^ vs_f ^ bl_r ^ bl_f;

  state_t state_q, state_d;
  logic [HW-1:0]  hcnt_q, hcnt_d, acnt_q, acnt_d;
  logic [HSW-1:0] swcnt_q, swcnt_d;
  logic [HW-1:0]  line_total_q, line_total_d, line_active_q, line_active_d;
  logic [HSW-1:0] line_sync_q, line_sync_d;
  logic [VW-1:0]  vcnt_q, vcnt_d, vacnt_q, vacnt_d;
  logic [VSW-1:0] vswcnt_q, vswcnt_d;
  logic [TIMEOUT_W-1:0] wdog_q, wdog_d;
  logic [HW-1:0]  h_total_q, h_total_d, h_active_q, h_active_d;
  logic [HSW-1:0] h_sync_w_q, h_sync_w_d;
  logic [VW-1:0]  v_total_q, v_total_d, v_active_q, v_active_d;
  logic [VSW-1:0] v_sync_w_q, v_sync_w_d;
  logic locked_q, locked_d, changed_q, changed_d;

  logic [VW-1:0]  frame_vt, frame_va;
  logic [VSW-1:0] frame_vsw;
  logic run, timeout, publish, match;

  always_comb begin
    state_d       = state_q;
    hcnt_d        = hcnt_q;
    acnt_d        = acnt_q;
    swcnt_d       = swcnt_q;
    line_total_d  = line_total_q;
    line_active_d = line_active_q;
    line_sync_d   = line_sync_q;
    vcnt_d        = vcnt_q;
    vacnt_d       = vacnt_q;
    vswcnt_d      = vswcnt_q;
    wdog_d        = wdog_q;
    h_total_d     = h_total_q;
    h_sync_w_d    = h_sync_w_q;
    h_active_d    = h_active_q;
    v_total_d     = v_total_q;
    v_sync_w_d    = v_sync_w_q;
    v_active_d    = v_active_q;
    locked_d      = locked_q;
    changed_d     = 1'b0;
    frame_vt      = vcnt_q;
    frame_va      = vacnt_q;
    frame_vsw     = vswcnt_q;
    publish       = 1'b0;
    match         = 1'b0;
    run           = (state_q != WAIT) || vs_r;
    timeout       = ce_pix && !vs_r && (wdog_q == '1);

    if (vs_r) begin
      wdog_d = '0;
    end else if (ce_pix && (wdog_q != '1)) begin
      wdog_d = wdog_q + TIMEOUT_W'(1);
    end

    if (!run) begin
      hcnt_d        = '0;
      acnt_d        = '0;
      swcnt_d       = '0;
      line_total_d  = '0;
      line_active_d = '0;
      line_sync_d   = '0;
      vcnt_d        = '0;
      vacnt_d       = '0;
      vswcnt_d      = '0;
    end else if (ce_pix) begin
      // The HS rise tick is tick 0 of the new line; the finished line is latched first.
      if (hs_r) begin
        line_total_d  = HW'(sat_inc(16'(hcnt_q), HW));
        line_active_d = acnt_q;
        line_sync_d   = swcnt_q;
        hcnt_d        = '0;
        acnt_d        = bl_l ? '0 : HW'(1);
        swcnt_d       = hs_l ? HSW'(1) : '0;
        vcnt_d        = VW'(sat_inc(16'(vcnt_q), VW));
        if (vs_l)          vswcnt_d = VSW'(sat_inc(16'(vswcnt_q), VSW));
        if (acnt_q != '0)  vacnt_d  = VW'(sat_inc(16'(vacnt_q), VW));
      end else begin
        hcnt_d = HW'(sat_inc(16'(hcnt_q), HW));
        if (!bl_l) acnt_d  = HW'(sat_inc(16'(acnt_q), HW));
        if (hs_l)  swcnt_d = HSW'(sat_inc(16'(swcnt_q), HSW));
      end
      // A coincident HS rise closes the ending frame but starts the new VS pulse.
      if (vs_r) begin
        frame_vt  = vcnt_d;
        frame_va  = vacnt_d;
        frame_vsw = vswcnt_q;
        vcnt_d    = '0;
        vacnt_d   = '0;
        vswcnt_d  = VSW'(hs_r);
      end
    end

    match = (line_total_d == h_total_q) && (frame_vt == v_total_q);

    if (vs_r) begin
      case (state_q)
        WAIT:    state_d = FIRST;
        FIRST: begin
          state_d = VERIFY;
          publish = 1'b1;
        end
        VERIFY: begin
          publish = 1'b1;
          if (match) begin
            state_d  = LOCK;
            locked_d = 1'b1;
          end
        end
        LOCK: begin
          publish = 1'b1;
          if (!match) begin
            state_d   = VERIFY;
            locked_d  = 1'b0;
            changed_d = 1'b1;
          end
        end
        default: state_d = WAIT;
      endcase
    end else if (timeout) begin
      state_d   = WAIT;
      locked_d  = 1'b0;
      changed_d = (state_q == LOCK);
    end

    if (publish) begin
      h_total_d  = line_total_d;
      h_sync_w_d = line_sync_d;
      h_active_d = line_active_d;
      v_total_d  = frame_vt;
      v_sync_w_d = frame_vsw;
      v_active_d = frame_va;
    end
  end

  always_ff @(posedge clk_24m or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= WAIT;
      hcnt_q        <= '0;
      acnt_q        <= '0;
      swcnt_q       <= '0;
      line_total_q  <= '0;
      line_active_q <= '0;
      line_sync_q   <= '0;
      vcnt_q        <= '0;
      vacnt_q       <= '0;
      vswcnt_q      <= '0;
      wdog_q        <= '0;
      h_total_q     <= '0;
      h_sync_w_q    <= '0;
      h_active_q    <= '0;
      v_total_q     <= '0;
      v_sync_w_q    <= '0;
      v_active_q    <= '0;
      locked_q      <= 1'b0;
      changed_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      hcnt_q        <= hcnt_d;
      acnt_q        <= acnt_d;
      swcnt_q       <= swcnt_d;
      line_total_q  <= line_total_d;
      line_active_q <= line_active_d;
      line_sync_q   <= line_sync_d;
      vcnt_q        <= vcnt_d;
      vacnt_q       <= vacnt_d;
      vswcnt_q      <= vswcnt_d;
      wdog_q        <= wdog_d;
      h_total_q     <= h_total_d;
      h_sync_w_q    <= h_sync_w_d;
      h_active_q    <= h_active_d;
      v_total_q     <= v_total_d;
      v_sync_w_q    <= v_sync_w_d;
      v_active_q    <= v_active_d;
      locked_q      <= locked_d;
      changed_q     <= changed_d;
    end
  end

  assign h_total  = h_total_q;
  assign h_sync_w = h_sync_w_q;
  assign h_active = h_active_q;
  assign v_total  = v_total_q;
  assign v_sync_w = v_sync_w_q;
  assign v_active = v_active_q;
  assign locked   = locked_q;
  assign changed  = changed_q;

endmodule

// File: tb/tb_video_timing_meter.sv
// Directed bench for video_timing_meter using a scaled raster (40 ticks x 20 lines,
// coordinates relative to the HS rise) with ce_pix on every other clock.
module tb_video_timing_meter;

  logic        clk_24m = 1'b0;
  logic        reset_n;
  logic        ce_pix;
  logic        hs_in, vs_in, blank_in;
  logic [10:0] h_total, h_active;
  logic [7:0]  h_sync_w;
  logic [9:0]  v_total, v_active;
  logic [4:0]  v_sync_w;
  logic        locked, changed;

  int checks = 0;
  int errors = 0;
  int chg_cnt = 0;

  video_timing_meter #(.SYNC_STAGES(2), .TIMEOUT_W(12)) dut (
    .clk_24m(clk_24m), .reset_n(reset_n), .ce_pix(ce_pix),
    .hs_in(hs_in), .vs_in(vs_in), .blank_in(blank_in),
    .h_total(h_total), .h_sync_w(h_sync_w), .h_active(h_active),
    .v_total(v_total), .v_sync_w(v_sync_w), .v_active(v_active),
    .locked(locked), .changed(changed)
  );

  always #21 clk_24m = ~clk_24m;

  always @(negedge clk_24m) if (changed) chg_cnt++;

  initial begin
    #10_000_000;
    $display("FAIL global_timeout got running expected finished");
    $fatal(1);
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_out(input string tag, input int ht, input int hsw, input int ha,
                           input int vt, input int vsw, input int va, input int lk);
    check({tag, ".h_total"},  int'(h_total),  ht);
    check({tag, ".h_sync_w"}, int'(h_sync_w), hsw);
    check({tag, ".h_active"}, int'(h_active), ha);
    check({tag, ".v_total"},  int'(v_total),  vt);
    check({tag, ".v_sync_w"}, int'(v_sync_w), vsw);
    check({tag, ".v_active"}, int'(v_active), va);
    check({tag, ".locked"},   int'(locked),   lk);
  endtask

  task automatic tick(input logic hs, input logic vs, input logic bl);
    @(negedge clk_24m);
    hs_in = hs; vs_in = vs; blank_in = bl; ce_pix = 1'b1;
    @(negedge clk_24m);
    ce_pix = 1'b0;
  endtask

  // Line w starts with its HS rise; VS covers lines 0..2, vblank lines 0..4,
  // HS ticks 0..5, hblank ticks 0..9 and the last 4 ticks of each line.
  task automatic drive_lines(input int first_w, input int n, input int len, input int last_len);
    for (int i = 0; i < n; i++) begin
      int w;
      int l;
      w = first_w + i;
      l = (i == n - 1) ? last_len : len;
      for (int u = 0; u < l; u++)
        tick(u < 6, w < 3, (w < 5) || (u < 10) || (u >= l - 4));
    end
  endtask

  typedef struct {
    int nlines; int len; int last;
    int ht; int hsw; int ha; int vt; int vsw; int va; int lk; int chg;
  } vec_t;

  vec_t vecs [12];

  initial begin
    int c0;
    reset_n = 1'b0; ce_pix = 1'b0; hs_in = 1'b0; vs_in = 1'b0; blank_in = 1'b0;
    repeat (3) @(negedge clk_24m);
    check_out("reset", 0, 0, 0, 0, 0, 0, 0);
    check("reset.changed", int'(changed), 0);
    reset_n = 1'b1;
    repeat (4) tick(1'b0, 1'b0, 1'b1);

    // Each row drives one frame; expectations are the snapshot published at its first VS rise.
    vecs[0]  = '{20, 40, 40,      0, 0,    0,  0, 0,  0, 0, 0};
    vecs[1]  = '{20, 40, 40,     40, 6,   26, 20, 3, 15, 0, 0};
    vecs[2]  = '{20, 41, 41,     40, 6,   26, 20, 3, 15, 1, 0};
    vecs[3]  = '{20, 41, 41,     41, 6,   27, 20, 3, 15, 0, 1};
    vecs[4]  = '{20, 41, 41,     41, 6,   27, 20, 3, 15, 1, 0};
    vecs[5]  = '{20, 40, 3000,   41, 6,   27, 20, 3, 15, 1, 0};
    vecs[6]  = '{20, 40, 40,   2047, 6, 2047, 20, 3, 15, 0, 1};
    vecs[7]  = '{20, 40, 40,     40, 6,   26, 20, 3, 15, 0, 0};
    vecs[8]  = '{21, 40, 40,     40, 6,   26, 20, 3, 15, 1, 0};
    vecs[9]  = '{20, 40, 40,     40, 6,   26, 21, 3, 16, 0, 1};
    vecs[10] = '{20, 40, 40,     40, 6,   26, 20, 3, 15, 0, 0};
    vecs[11] = '{20, 40, 40,     40, 6,   26, 20, 3, 15, 1, 0};

    for (int i = 0; i < 12; i++) begin
      c0 = chg_cnt;
      drive_lines(0, vecs[i].nlines, vecs[i].len, vecs[i].last);
      check_out($sformatf("vec%0d", i), vecs[i].ht, vecs[i].hsw, vecs[i].ha,
                vecs[i].vt, vecs[i].vsw, vecs[i].va, vecs[i].lk);
      check($sformatf("vec%0d.changed_pulses", i), chg_cnt - c0, vecs[i].chg);
    end

    // VS stops while locked: watchdog drops lock, snapshot is held.
    c0 = chg_cnt;
    drive_lines(20, 110, 40, 40);
    check_out("vs_lost", 40, 6, 26, 20, 3, 15, 0);
    check("vs_lost.changed_pulses", chg_cnt - c0, 1);

    c0 = chg_cnt;
    drive_lines(0, 20, 40, 40);
    check("relock1.locked", int'(locked), 0);
    drive_lines(0, 20, 40, 40);
    check("relock2.locked", int'(locked), 0);
    drive_lines(0, 20, 40, 40);
    check_out("relock3", 40, 6, 26, 20, 3, 15, 1);
    check("relock.changed_pulses", chg_cnt - c0, 0);

    // Asynchronous reset mid-frame while locked.
    drive_lines(0, 10, 40, 40);
    check("pre_reset.locked", int'(locked), 1);
    c0 = chg_cnt;
    #5 reset_n = 1'b0;
    #1 check_out("async_reset", 0, 0, 0, 0, 0, 0, 0);
    repeat (3) tick(1'b0, 1'b0, 1'b1);
    @(negedge clk_24m);
    reset_n = 1'b1;
    drive_lines(10, 10, 40, 40);
    check_out("post_reset", 0, 0, 0, 0, 0, 0, 0);
    drive_lines(0, 20, 40, 40);
    check("rst_relock1.locked", int'(locked), 0);
    drive_lines(0, 20, 40, 40);
    check("rst_relock2.locked", int'(locked), 0);
    drive_lines(0, 20, 40, 40);
    check_out("rst_relock3", 40, 6, 26, 20, 3, 15, 1);
    check("rst.changed_pulses", chg_cnt - c0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
